// File: rtl/boron_key_schedule.sv
// ---------------------------------------------------------------------------
// boron_key_schedule
//
// Iterative BORON 80-bit key schedule feeding the round datapath. A master
// key is loaded on start_i and one round key is presented per accepted
// valid/ready handshake, K0 .. K(NUM_ROUNDS), final whitening key included.
// One step is computed per cycle; all outputs come straight from registers.
//
// Optional build macro: BORON_KS_REVERSE_EN
//   Adds dir_i. dir_i=1 (sampled with start_i) pre-computes K(NUM_ROUNDS)
//   silently, then walks the schedule backwards with the inverse step so the
//   keys come out in decryption order. Without the macro the block is
//   forward-only and carries no inverse S-box logic.
//
// Ports:
//   clk_i       in   1   rising-edge clock
//   rst_ni      in   1   asynchronous active-low reset
//   start_i     in   1   load key_i and start a schedule (IDLE / DONE only)
//   dir_i       in   1   (macro only) 1 = decryption order
//   key_i       in  80   master key K0
//   rk_o        out 80   current round key (low 64 bits = round-key word)
//   rk_idx_o    out  5   index of the key on rk_o
//   rk_valid_o  out  1   rk_o / rk_idx_o hold a valid key
//   rk_ready_i  in   1   consumer accepts the key this cycle
//   busy_o      out  1   schedule in progress (not IDLE, not DONE)
//   done_o      out  1   one-cycle pulse after the last key is accepted
// ---------------------------------------------------------------------------
module boron_key_schedule #(
  parameter int NUM_ROUNDS = 25,
  parameter int RC_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
`ifdef BORON_KS_REVERSE_EN
  input  logic        dir_i,
`endif
  input  logic [79:0] key_i,
  output logic [79:0] rk_o,
  output logic [4:0]  rk_idx_o,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS);

`ifdef BORON_KS_REVERSE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_PRELOAD = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
`endif

  state_t            state_r;
  logic [79:0]       rk_r;
  logic [4:0]        rk_idx_r;
  logic              rk_valid_r;
  logic              busy_r;
  logic              done_r;
  logic [RC_W-1:0]   rc_fwd_s;
  logic [79:0]       key_fwd_s;
`ifdef BORON_KS_REVERSE_EN
  logic              dir_r;
  logic [RC_W-1:0]   rc_inv_s;
  logic [79:0]       key_inv_s;
`endif

  // 4-bit substitution applied to the low nibble after rotation
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Forward step: rotate left 13, substitute low nibble, inject constant
  function automatic logic [79:0] step_fwd(input logic [79:0] k,
                                           input logic [RC_W-1:0] c);
    logic [79:0] r;
    r              = {k[66:0], k[79:67]};
    r[3:0]         = sbox(r[3:0]);
    r[63 -: RC_W]  = r[63 -: RC_W] ^ c;
    return r;
  endfunction

`ifdef BORON_KS_REVERSE_EN
  // Inverse of sbox()
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h5;
      4'h1:    y = 4'hE;
      4'h2:    y = 4'hF;
      4'h3:    y = 4'h8;
      4'h4:    y = 4'hC;
      4'h5:    y = 4'h1;
      4'h6:    y = 4'h2;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'hB;
      4'h9:    y = 4'h4;
      4'hA:    y = 4'h6;
      4'hB:    y = 4'h3;
      4'hC:    y = 4'h0;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Inverse step: undo the constant, undo the S-box, rotate right 13
  function automatic logic [79:0] step_inv(input logic [79:0] k,
                                           input logic [RC_W-1:0] c);
    logic [79:0] r;
    r              = k;
    r[63 -: RC_W]  = r[63 -: RC_W] ^ c;
    r[3:0]         = sbox_inv(r[3:0]);
    return {r[12:0], r[79:13]};
  endfunction
`endif

  // Candidate next keys derived from the key currently held on rk_o
  always_comb begin
    // forward uses idx+1 as constant; inverse undoes the constant of the current idx
    rc_fwd_s  = RC_W'(rk_idx_r + 5'd1);
    key_fwd_s = step_fwd(rk_r, rc_fwd_s);
`ifdef BORON_KS_REVERSE_EN
    rc_inv_s  = RC_W'(rk_idx_r);
    key_inv_s = step_inv(rk_r, rc_inv_s);
`endif
  end

  // Schedule controller and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      rk_r       <= 80'd0;
      rk_idx_r   <= 5'd0;
      rk_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef BORON_KS_REVERSE_EN
      dir_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // done_o is a single-cycle pulse; any restart raises valid only
          // on the following edge, so the two never overlap
          done_r <= 1'b0;
          if (start_i) begin
            rk_r     <= key_i;
            rk_idx_r <= 5'd0;
            busy_r   <= 1'b1;
`ifdef BORON_KS_REVERSE_EN
            dir_r    <= dir_i;
            if (dir_i) begin
              rk_valid_r <= 1'b0;
              state_r    <= ST_PRELOAD;
            end else begin
              rk_valid_r <= 1'b1;
              state_r    <= ST_ISSUE;
            end
`else
            rk_valid_r <= 1'b1;
            state_r    <= ST_ISSUE;
`endif
          end else begin
            rk_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= state_r;
          end
        end

        ST_ISSUE: begin
          done_r <= 1'b0;
          if (rk_valid_r && rk_ready_i) begin
`ifdef BORON_KS_REVERSE_EN
            if (dir_r) begin
              if (rk_idx_r == 5'd0) begin
                rk_valid_r <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
                state_r    <= ST_DONE;
              end else begin
                rk_r     <= key_inv_s;
                rk_idx_r <= rk_idx_r - 5'd1;
              end
            end else
`endif
            if (rk_idx_r == LAST_IDX) begin
              rk_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              rk_r     <= key_fwd_s;
              rk_idx_r <= rk_idx_r + 5'd1;
            end
          end else begin
            // stalled: everything visible holds its value
            state_r <= ST_ISSUE;
          end
        end

`ifdef BORON_KS_REVERSE_EN
        ST_PRELOAD: begin
          // walk forward silently; the last step lands on K(NUM_ROUNDS)
          // and is presented in the same edge
          done_r   <= 1'b0;
          rk_r     <= key_fwd_s;
          rk_idx_r <= rk_idx_r + 5'd1;
          if ((rk_idx_r + 5'd1) == LAST_IDX) begin
            rk_valid_r <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            rk_valid_r <= 1'b0;
            state_r    <= ST_PRELOAD;
          end
        end
`endif

        default: begin
          state_r    <= ST_IDLE;
          rk_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign rk_o       = rk_r;
  assign rk_idx_o   = rk_idx_r;
  assign rk_valid_o = rk_valid_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;

endmodule

// File: tb/tb_boron_key_schedule.sv
`timescale 1ns/1ps
module tb_boron_key_schedule;

  localparam int NR = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [79:0] key;
  logic [79:0] rk;
  logic [4:0]  idx;
  logic        valid;
  logic        busy;
  logic        done;
`ifdef BORON_KS_REVERSE_EN
  logic        dir;
`endif

  always #5 clk = ~clk;

  boron_key_schedule #(.NUM_ROUNDS(NR), .RC_W(5)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
`ifdef BORON_KS_REVERSE_EN
    .dir_i      (dir),
`endif
    .key_i      (key),
    .rk_o       (rk),
    .rk_idx_o   (idx),
    .rk_valid_o (valid),
    .rk_ready_i (ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [79:0] model [0:31];

  typedef struct {
    logic [79:0] k;
    int          at;
    logic [79:0] exp;
  } vec_t;
  vec_t vecs [5];

  // reference step: rotate, substitute, xor constant
  function automatic logic [79:0] fstep(input logic [79:0] k, input int c);
    logic [79:0] r;
    r = (k << 13) | (k >> 67);
    r[3:0] = sb[r[3:0]];
    r[63:59] = r[63:59] ^ 5'(c);
    return r;
  endfunction

  task automatic build(input logic [79:0] k);
    model[0] = k;
    for (int i = 1; i <= NR; i++) model[i] = fstep(model[i-1], i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_sched(input logic [79:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int w = 0; w < 200 && !done; w++) tick();
    chk("drain_done", {95'd0, done}, 96'd1);
    tick();
  endtask

  task automatic wait_idx(input logic [4:0] target);
    for (int w = 0; w < 100 && idx != target; w++) tick();
    chk("wait_idx", {91'd0, idx}, {91'd0, target});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] ka;
    logic [79:0] ones;
    int          hs;
    logic        done_seen;
    int          cnt;

    ones  = '1;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    key   = 80'd0;
`ifdef BORON_KS_REVERSE_EN
    dir   = 1'b0;
`endif
    #2;
    chk("reset_state", {8'd0, rk, idx, valid, busy, done}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {94'd0, valid, busy}, 96'd0);

    // ---- table-driven single-key checks ----
    ka = {$urandom, $urandom, 16'($urandom)};
    vecs[0] = '{k: 80'd0, at: 0, exp: 80'd0};
    vecs[1] = '{k: 80'd0, at: 1, exp: 80'h0000_0800_0000_0000_000C};
    vecs[2] = '{k: 80'd0, at: 2, exp: 80'h0100_1000_0000_0001_800C};
    vecs[3] = '{k: ones,  at: 0, exp: ones};
    build(ka);
    vecs[4] = '{k: ka, at: 7, exp: model[7]};
    for (int v = 0; v < 5; v++) begin
      ready = 1'b1;
      start_sched(vecs[v].k);
      for (int t = 0; t < vecs[v].at; t++) tick();
      chk($sformatf("table_%0d", v), {10'd0, valid, idx, rk},
          {10'd0, 1'b1, 5'(vecs[v].at), vecs[v].exp});
      drain();
    end

    // ---- zero key, full forward stream ----
    build(80'd0);
    ready = 1'b1;
    start_sched(80'd0);
    for (int i = 0; i <= NR; i++) begin
      chk($sformatf("fwd_k%0d", i), {10'd0, valid, idx, rk},
          {10'd0, 1'b1, 5'(i), model[i]});
      tick();
    end
    chk("fwd_end", {93'd0, valid, busy, done}, {93'd0, 3'b001});
    tick();
    chk("done_drop", {95'd0, done}, 96'd0);

    // ---- backpressure at idx 3 ----
    start_sched(80'd0);
    wait_idx(5'd3);
    ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("stall_hold", {10'd0, valid, idx, rk}, {10'd0, 1'b1, 5'd3, model[3]});
    end
    ready = 1'b1;
    tick();
    chk("stall_release", {10'd0, valid, idx, rk}, {10'd0, 1'b1, 5'd4, model[4]});
    drain();

    // ---- random keys, random ready ----
    for (int s = 0; s < 4; s++) begin
      ka = {$urandom, $urandom, 16'($urandom)};
      build(ka);
      ready = 1'b0;
      start_sched(ka);
      hs = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 400 && !done_seen; c++) begin
        ready = 1'($urandom_range(0, 1));
        if (valid && ready) begin
          chk("rand_handshake", {11'd0, idx, rk}, {11'd0, 5'(hs), model[hs % 32]});
          hs++;
        end
        tick();
        if (done) done_seen = 1'b1;
      end
      chk("rand_count", {95'd0, done_seen} + 96'(hs), 96'(NR + 2));
      tick();
    end

    // ---- reset in mid-schedule ----
    ready = 1'b1;
    start_sched(80'h1234_5678_9ABC_DEF0_1357);
    wait_idx(5'd10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {8'd0, rk, idx, valid, busy, done}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("post_reset_idle", {94'd0, valid, busy}, 96'd0);
    end

    // ---- ignored start mid-run, then restart from DONE ----
    ka = {$urandom, $urandom, 16'($urandom)};
    build(ka);
    ready = 1'b1;
    start_sched(ka);
    for (int i = 0; i <= NR; i++) begin
      chk($sformatf("ign_k%0d", i), {10'd0, valid, idx, rk},
          {10'd0, 1'b1, 5'(i), model[i]});
      if (i == 5) begin
        key   = ~ka;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("ign_done", {94'd0, valid, done}, {94'd0, 2'b01});
    start_sched(ones);
    chk("restart_ones", {9'd0, valid, done, idx, rk}, {9'd0, 1'b1, 1'b0, 5'd0, ones});
    drain();

`ifdef BORON_KS_REVERSE_EN
    // ---- reverse order, zero key ----
    build(80'd0);
    dir   = 1'b1;
    ready = 1'b1;
    start_sched(80'd0);
    dir = 1'b0;
    cnt = 1;
    while (!valid && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("rev_latency", 96'(cnt), 96'(NR + 1));
    for (int i = NR; i >= 0; i--) begin
      chk($sformatf("rev_k%0d", i), {10'd0, valid, idx, rk},
          {10'd0, 1'b1, 5'(i), model[i]});
      tick();
    end
    chk("rev_done", {94'd0, valid, done}, {94'd0, 2'b01});
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boron_key_schedule.md
Name: boron_key_schedule

Overview:
- Iterative BORON 80-bit key schedule, directly upstream of the round datapath.
- Loads a master key, then emits one 80-bit round key per accepted handshake: K0..K(NUM_ROUNDS), including the final whitening key.
- One step per cycle, with a registered output and valid/ready backpressure, so the round stage or its controller can stall freely.

Parameters:
- NUM_ROUNDS, 25: number of cipher rounds. Keys issued are K0..K(NUM_ROUNDS), i.e. NUM_ROUNDS+1 keys. Legal range 1..31.
- RC_W, 5: width of the round-constant field XORed into the key.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  load key_i and begin a schedule. Sampled only in IDLE or DONE.
- key_i  input  80  master key K0.
- rk_o  output  80  current round key; low 64 bits are the round-key word.
- rk_idx_o  output  5  index of the key on rk_o (0..NUM_ROUNDS).
- rk_valid_o  output  1  rk_o / rk_idx_o hold a valid key.
- rk_ready_i  input  1  consumer accepts the key this cycle.
- busy_o  output  1  high in any state other than IDLE and DONE.
- done_o  output  1  high for exactly one cycle after the last key is accepted.

Behaviour:
- Reset (asynchronous, rst_ni=0): state=IDLE; rk_o=0, rk_idx_o=0, rk_valid_o=0, busy_o=0, done_o=0. Reset mid-schedule aborts immediately; no further keys are issued.
- Step function F(K, c):
  - R = K rotated left by 13 (80-bit).
  - R[3:0] = S(R[3:0]), using S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0..F).
  - R[63:59] ^= c[4:0].
  - K(i) = F(K(i-1), i) for i = 1..NUM_ROUNDS.
- States:
  - IDLE: start_i=1 → rk_o<=key_i, rk_idx_o<=0, rk_valid_o<=1, go to ISSUE. Latency from start to first valid is 1 cycle.
  - ISSUE: hold rk_o stable while rk_valid_o=1 && rk_ready_i=0.
    - On handshake with rk_idx_o<NUM_ROUNDS: rk_o<=F(rk_o, rk_idx_o+1), rk_idx_o++, rk_valid_o stays 1. Back-to-back acceptance yields one key per cycle.
    - On handshake with rk_idx_o==NUM_ROUNDS: rk_valid_o<=0, done_o<=1, go to DONE.
  - DONE: done_o drops after one cycle. rk_o and rk_idx_o keep their last values. start_i=1 restarts exactly as from IDLE; done_o and the new rk_valid_o are never high together.
- start_i in ISSUE (or PRELOAD) is ignored; no restart mid-schedule.
- Simultaneous start_i and reset deassertion edge: reset wins for that cycle.
- rk_ready_i while rk_valid_o=0 has no effect.
- The round constant is computed from rk_idx_o+1 truncated to RC_W bits. No wrap occurs for legal NUM_ROUNDS.

Optional Feature:
- Macro: BORON_KS_REVERSE_EN. It adds input dir_i (1 bit, sampled with start_i); dir_i=1 selects decryption order.
- With the macro, dir_i=1:
  - IDLE→PRELOAD: run F silently for NUM_ROUNDS cycles with rk_valid_o=0 and busy_o=1.
  - Then issue K(NUM_ROUNDS) first, rk_idx_o=NUM_ROUNDS.
  - Each handshake applies the inverse step G(K, c): R = K; R[63:59] ^= c; R[3:0] = S⁻¹(R[3:0]); rotate right by 13. Use c = current rk_idx_o, then decrement rk_idx_o.
  - The handshake at index 0 ends the schedule (done_o pulse).
  - dir_i=0 behaves as the forward schedule.
- Without the macro: no dir_i port, no PRELOAD state, no inverse S-box logic; forward only.

Test Plan:
- Zero key forward: key_i=0, start pulse, rk_ready_i=1 constant → cycle+1 rk_o=0 idx 0; cycle+2 rk_o=0x0000_0800_0000_0000_000C idx 1; 26 keys in 26 consecutive cycles; done_o pulse one cycle after idx 25 is accepted.
- Backpressure: same key, rk_ready_i=0 for 5 cycles at idx 3 → rk_o, rk_idx_o, rk_valid_o unchanged for all 5 cycles; next key appears one cycle after ready rises.
- Golden model: random keys and random rk_ready_i (50%) → every accepted (idx, rk_o) pair matches a software F model; exactly 26 handshakes per schedule.
- Reset mid-run: assert rst_ni=0 at idx 10 → outputs zero asynchronously, before the next clock edge; after release, state is IDLE and no valid appears until start_i.
- Ignored start and restart: start_i pulsed at idx 5 with a different key → sequence unaffected. start_i in DONE with key_i=all-ones → idx 0 rk_o=0xFFFF_FFFF_FFFF_FFFF_FFFF.
- With BORON_KS_REVERSE_EN: dir_i=1, key_i=0 → first valid after NUM_ROUNDS+1 cycles with idx 25 equal to forward K25; sequence ends with idx 1 = 0x0000_0800_0000_0000_000C, then idx 0 = 0, then done_o.
